cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//  - Run/step controller between the slow-clock divider and the single-cycle CPU.
//  - Consumes the divider's slow square wave (tick_in) and board switch/button inputs.
//  - Produces a one-clk-wide CPU clock enable (cpu_ce) in free-run or single-step mode.
//  - Keeps a count of executed CPU cycles for the board display.
// PARAMETERS
//  DB_CYCLES  1000000  debounce window in clk cycles (10 ms at 100 MHz); sims use 4
//  CNT_W      32       width of cycle_cnt
//  PC_W       32       width of pc / bp_addr
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-low reset
//  tick_in    in   1      slow clock level from the divider; each rising edge = one CPU cycle slot
//  run_sw     in   1      async switch; 1 = free-run, 0 = stop
//  step_btn   in   1      async push-button, bouncy; each debounced press = one step
//  pc         in   PC_W   current CPU PC (used only with BREAKPOINT_EN)
//  bp_addr    in   PC_W   breakpoint address (used only with BREAKPOINT_EN)
//  bp_valid   in   1      breakpoint armed (used only with BREAKPOINT_EN)
//  cpu_ce     out  1      CPU clock enable, one clk wide
//  state_out  out  2      FSM state: IDLE=00, RUN=01, STEP=10, HALT=11
//  cycle_cnt  out  CNT_W  number of cpu_ce pulses issued
// BEHAVIOUR
//  - Reset: all sync FFs 0, debounced level 0, debounce count 0; state IDLE; cpu_ce 0; cycle_cnt 0.
//  - Synchronisers: tick_in, run_sw and step_btn each pass through a 2-FF synchroniser.
//  - tick_rise = tick_s & ~tick_d, where tick_d is tick_s delayed by one clk.
//  - Latency: cpu_ce is high after the 3rd clk edge counted from the edge that first samples tick_in=1.
//  - Debounce:
//    - The counter runs while btn_s != stable and clears whenever btn_s == stable.
//    - When the count reaches DB_CYCLES-1: stable <= btn_s and the counter clears.
//    - step_press = one-clk pulse on a 0->1 transition of stable. Release produces no pulse.
//  - FSM (registered):
//    - IDLE: run_s -> RUN; else step_press -> STEP.
//    - RUN: cpu_ce <= tick_rise.
//      - run_s==0 -> IDLE, and this takes priority: no cpu_ce is issued in that cycle.
//      - step_press is ignored.
//    - STEP:
//      - On tick_rise: cpu_ce <= 1 exactly once, then -> IDLE.
//      - run_s does not abort a pending step.
//      - Extra step_press pulses while in STEP are dropped, not queued.
//    - HALT: reachable only with BREAKPOINT_EN.
//      - run_s==0 -> IDLE.
//      - step_press -> STEP; the step executes the breakpoint instruction.
//  - cpu_ce is a registered output and is never high for two consecutive clks.
//  - cycle_cnt increments on each clk where cpu_ce==1. It wraps from all-ones to 0 without flagging.
//  - Reset asserted mid-step or mid-debounce: immediate return to reset values; the pending step is lost.
//  - Simultaneous run_s rise and step_press in IDLE: RUN wins and the press is dropped.
// CONFIGURATION
//  - Macro CPU_STEP_BREAKPOINT_EN defined:
//    - In RUN, on a tick_rise with bp_valid && pc==bp_addr: no cpu_ce is issued and state -> HALT.
//    - A step out of HALT is not re-checked against the breakpoint, so the CPU advances past it.
//  - Macro not defined:
//    - pc, bp_addr and bp_valid are present but ignored.
//    - HALT is unreachable; state_out never shows 11.
// STRUCTURE
//  - Shared package cpu_clk_pkg:
//    - state encoding localparams ST_IDLE, ST_RUN, ST_STEP, ST_HALT
//    - 2-bit state typedef
//    - DB_CYCLES default constant
//  - One sub-module: btn_debounce (2-FF sync + debounce counter + press pulse), parameterised by DB_CYCLES.
//  - Everything else stays in the top: tick edge detect, FSM, cycle counter.
// TESTING (DB_CYCLES=4, tick_in period 20 clk)
//  1. Reset release, run_sw=1, 5 tick_in rises -> 5 cpu_ce pulses, each 1 clk wide and 3 clk edges after its tick rise; cycle_cnt=5.
//  2. run_sw=0; step_btn bounces 0/1 every clk for 3 clk, then holds 1 for 10 clk -> exactly one step_press; the next tick gives 1 cpu_ce; state returns to 00.
//  3. Drop run_sw in the same clk that tick_rise occurs in RUN -> no cpu_ce; state_out=00.
//  4. Force cycle_cnt to all-ones, issue one step -> cycle_cnt=0.
//  5. Assert reset while in STEP before its tick -> cpu_ce stays 0, state_out=00, cycle_cnt=0 after release.
//  6. With CPU_STEP_BREAKPOINT_EN, bp_addr=0x0000000C, pc=0x0000000C, run -> state_out=11 with no ce; a step -> one cpu_ce, state_out=00.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: state encoding and default constants shared by the CPU run/step
// control slice.
package cpu_clk_pkg;

    // Encoding is visible on the board display, so it is fixed rather than left to the tools.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncy push-button and emits a one-clk pulse per
// debounced press; release produces no pulse.
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          btn_s1_q;
    logic          btn_s_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // The counter only survives while btn_s disagrees with the accepted level, so any bounce restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1_q <= 1'b0;
            btn_s_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            btn_s1_q <= btn_i;
            btn_s_q  <= btn_s1_q;
            press_q  <= 1'b0;
            if (btn_s_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_q <= btn_s_q;
                press_q  <= btn_s_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: free-run / single-step controller issuing a one-clk CPU clock enable.
// Define CPU_STEP_BREAKPOINT_EN to halt free-run when an armed bp_addr matches pc.
module cpu_step_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PC_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             cpu_ce,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] cycle_cnt
);

    logic             tick_s1_q, tick_s_q, tick_dly_q;
    logic             run_s1_q, run_s_q;
    logic             tick_rise;
    logic             step_press;
    logic             bp_hit;
    state_t           state_q;
    logic             cpu_ce_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_s1_q  <= 1'b0;
            tick_s_q   <= 1'b0;
            tick_dly_q <= 1'b0;
            run_s1_q   <= 1'b0;
            run_s_q    <= 1'b0;
        end else begin
            tick_s1_q  <= tick_in;
            tick_s_q   <= tick_s1_q;
            tick_dly_q <= tick_s_q;
            run_s1_q   <= run_sw;
            run_s_q    <= run_s1_q;
        end
    end

    assign tick_rise = tick_s_q & ~tick_dly_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (step_btn),
        .press_o (step_press)
    );

`ifdef CPU_STEP_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc == bp_addr);
`else
    logic unused_bp;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

    // cpu_ce only follows a single-clk tick_rise, so it can never be high on consecutive clks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cpu_ce_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            cpu_ce_q    <= 1'b0;
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(cpu_ce_q);
            case (state_q)
                ST_IDLE: begin
                    if (run_s_q)         state_q <= ST_RUN;
                    else if (step_press) state_q <= ST_STEP;
                end
                ST_RUN: begin
                    if (!run_s_q)                 state_q  <= ST_IDLE;
                    else if (tick_rise && bp_hit) state_q  <= ST_HALT;
                    else                          cpu_ce_q <= tick_rise;
                end
                ST_STEP: begin
                    // A step out of HALT lands here too and is deliberately not re-checked against the breakpoint.
                    if (tick_rise) begin
                        cpu_ce_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (!run_s_q)        state_q <= ST_IDLE;
                    else if (step_press) state_q <= ST_STEP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign state_out = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed scenarios plus randomized traffic against an
// edge-history reference model of the run/step controller.
module tb_cpu_step_ctrl;

    localparam int DB    = 4;
    localparam int CNT_W = 4;
    localparam int PC_W  = 32;
`ifdef CPU_STEP_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif
    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_RUN  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_HALT = 2'b11;

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             tick_in  = 1'b0;
    logic             run_sw   = 1'b0;
    logic             step_btn = 1'b0;
    logic             bp_valid = 1'b0;
    logic [PC_W-1:0]  pc       = '0;
    logic [PC_W-1:0]  bp_addr  = '0;
    logic             cpu_ce;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] cycle_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .DB_CYCLES (DB),
        .CNT_W     (CNT_W),
        .PC_W      (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .cpu_ce    (cpu_ce),
        .state_out (state_out),
        .cycle_cnt (cycle_cnt)
    );

    // Reference model: keeps the raw input sampled at each clk edge (bit k = k edges ago)
    // and applies the behavioural rules directly to that history.
    logic [DB+1:0]    tk_h = '0;
    logic [DB+1:0]    rn_h = '0;
    logic [DB+1:0]    bt_h = '0;
    logic             m_stable = 1'b0;
    int               since_flip = DB;
    logic             press_pend = 1'b0;
    logic [1:0]       m_mode = M_IDLE;
    logic             m_ce = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    always @(posedge clk or negedge reset) begin
        logic rise, run_v, press_v, hit, ce_next;
        if (!reset) begin
            tk_h = '0; rn_h = '0; bt_h = '0;
            m_stable = 1'b0; since_flip = DB; press_pend = 1'b0;
            m_mode = M_IDLE; m_ce = 1'b0; m_cnt = '0;
        end else begin
            tk_h = {tk_h[DB:0], tick_in};
            rn_h = {rn_h[DB:0], run_sw};
            bt_h = {bt_h[DB:0], step_btn};
            rise    = tk_h[2] && !tk_h[3];
            run_v   = rn_h[2];
            press_v = press_pend;
            press_pend = 1'b0;
            since_flip++;
            if (since_flip >= DB && bt_h[DB+1:2] == {DB{~m_stable}}) begin
                m_stable   = ~m_stable;
                since_flip = 0;
                press_pend = m_stable;
            end
            hit     = BP_EN && bp_valid && (pc == bp_addr);
            m_cnt   = m_cnt + CNT_W'(m_ce);
            ce_next = 1'b0;
            if (m_mode == M_IDLE) begin
                if (run_v) m_mode = M_RUN; else if (press_v) m_mode = M_STEP;
            end else if (m_mode == M_RUN) begin
                if (!run_v) m_mode = M_IDLE;
                else if (rise && hit) m_mode = M_HALT;
                else ce_next = rise;
            end else if (m_mode == M_STEP) begin
                if (rise) begin ce_next = 1'b1; m_mode = M_IDLE; end
            end else begin
                if (!run_v) m_mode = M_IDLE; else if (press_v) m_mode = M_STEP;
            end
            m_ce = ce_next;
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (cpu_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", cpu_ce); else n_pass++;
        n_chk++; if (state_out !== 2'b00) $display("FAIL reset_state: got %b want 00", state_out); else n_pass++;
        n_chk++; if (cycle_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (state_out !== 2'b00) $display("FAIL reset_release_state: got %b want 00", state_out); else n_pass++;
    endtask

    task automatic test_run();
        int pulses = 0;
        run_sw = 1'b1;
        repeat (6) @(negedge clk);
        n_chk++; if (state_out !== 2'b01) $display("FAIL run_enter: state %b want 01", state_out); else n_pass++;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 20; i++) begin
                tick_in = (i < 10);
                @(negedge clk);
                pulses += int'(cpu_ce);
                n_chk++;
                if (cpu_ce !== 1'(i == 2)) $display("FAIL run_ce_timing: tick %0d clk %0d ce %b want %b", t, i, cpu_ce, i == 2);
                else n_pass++;
            end
        end
        n_chk++; if (pulses != 5) $display("FAIL run_pulses: got %0d want 5", pulses); else n_pass++;
        n_chk++; if (cycle_cnt !== 4'd5) $display("FAIL run_cnt: got %0d want 5", cycle_cnt); else n_pass++;
    endtask

    task automatic test_step_debounce();
        int entries = 0;
        int pulses  = 0;
        logic [1:0] prev = 2'b01;
        run_sw = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++; if (state_out !== 2'b00) $display("FAIL step_idle: state %b want 00", state_out); else n_pass++;
        prev = state_out;
        for (int i = 0; i < 23; i++) begin
            step_btn = (i < 3) ? 1'(i % 2 == 0) : (i < 13);
            @(negedge clk);
            if (state_out == 2'b10 && prev != 2'b10) entries++;
            prev = state_out;
            n_chk++;
            if ({cpu_ce, state_out, cycle_cnt} !== {m_ce, m_mode, m_cnt})
                $display("FAIL step_press_model: clk %0d ce/st/cnt %b/%b/%0d want %b/%b/%0d", i, cpu_ce, state_out, cycle_cnt, m_ce, m_mode, m_cnt);
            else n_pass++;
        end
        n_chk++; if (entries != 1) $display("FAIL step_press_count: got %0d want 1", entries); else n_pass++;
        n_chk++; if (state_out !== 2'b10) $display("FAIL step_pending: state %b want 10", state_out); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick_in = (i < 10);
            @(negedge clk);
            pulses += int'(cpu_ce);
        end
        n_chk++; if (pulses != 1) $display("FAIL step_ce_count: got %0d want 1", pulses); else n_pass++;
        n_chk++; if (state_out !== 2'b00) $display("FAIL step_return: state %b want 00", state_out); else n_pass++;
        n_chk++; if (cycle_cnt !== 4'd6) $display("FAIL step_cnt: got %0d want 6", cycle_cnt); else n_pass++;
    endtask

    task automatic test_run_drop();
        int pulses = 0;
        logic [CNT_W-1:0] cnt_before;
        run_sw = 1'b1;
        repeat (8) @(negedge clk);
        n_chk++; if (state_out !== 2'b01) $display("FAIL drop_in_run: state %b want 01", state_out); else n_pass++;
        cnt_before = m_cnt;
        run_sw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_in = (i < 10);
            @(negedge clk);
            pulses += int'(cpu_ce);
        end
        n_chk++; if (pulses != 0) $display("FAIL drop_no_ce: got %0d pulses want 0", pulses); else n_pass++;
        n_chk++; if (state_out !== 2'b00) $display("FAIL drop_state: state %b want 00", state_out); else n_pass++;
        n_chk++; if (cycle_cnt !== cnt_before) $display("FAIL drop_cnt: got %0d want %0d", cycle_cnt, cnt_before); else n_pass++;
    endtask

    task automatic test_wrap();
        int pulses = 0;
        run_sw = 1'b1;
        repeat (6) @(negedge clk);
        for (int t = 0; t < 20 && m_cnt != '1; t++) begin
            for (int i = 0; i < 20; i++) begin
                tick_in = (i < 10);
                @(negedge clk);
            end
        end
        run_sw = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++; if (cycle_cnt !== 4'hF) $display("FAIL wrap_full: got %0d want 15", cycle_cnt); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step_btn = (i < 8);
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            tick_in = (i < 10);
            @(negedge clk);
            pulses += int'(cpu_ce);
        end
        n_chk++; if (pulses != 1) $display("FAIL wrap_step_ce: got %0d want 1", pulses); else n_pass++;
        n_chk++; if (cycle_cnt !== 4'h0) $display("FAIL wrap_zero: got %0d want 0", cycle_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_step();
        int pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step_btn = (i < 8);
            @(negedge clk);
        end
        n_chk++; if (state_out !== 2'b10) $display("FAIL rst_step_armed: state %b want 10", state_out); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if ({cpu_ce, state_out, cycle_cnt} !== 7'b0) $display("FAIL rst_step_during: ce/st/cnt %b/%b/%0d want 0/00/0", cpu_ce, state_out, cycle_cnt); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick_in = (i < 10);
            @(negedge clk);
            pulses += int'(cpu_ce);
        end
        n_chk++; if (pulses != 0) $display("FAIL rst_step_lost: got %0d pulses want 0", pulses); else n_pass++;
        n_chk++; if (state_out !== 2'b00) $display("FAIL rst_step_state: state %b want 00", state_out); else n_pass++;
        n_chk++; if (cycle_cnt !== '0) $display("FAIL rst_step_cnt: got %0d want 0", cycle_cnt); else n_pass++;
    endtask

    task automatic test_breakpoint();
        int pulses = 0;
        int halted = 0;
        bp_valid = 1'b1;
        bp_addr  = 32'h0000_000C;
        pc       = 32'h0000_000C;
        run_sw   = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            tick_in = (i < 10);
            @(negedge clk);
            pulses += int'(cpu_ce);
            if (state_out == 2'b11) halted++;
        end
`ifdef CPU_STEP_BREAKPOINT_EN
        n_chk++; if (pulses != 0) $display("FAIL bp_no_ce: got %0d pulses want 0", pulses); else n_pass++;
        n_chk++; if (state_out !== 2'b11) $display("FAIL bp_halt: state %b want 11", state_out); else n_pass++;
        for (int i = 0; i < 14; i++) begin
            step_btn = (i < 8);
            @(negedge clk);
        end
        n_chk++; if (state_out !== 2'b10) $display("FAIL bp_step_armed: state %b want 10", state_out); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick_in = 1'b1;
            @(negedge clk);
            pulses += int'(cpu_ce);
        end
        n_chk++; if (cpu_ce !== 1'b1) $display("FAIL bp_step_ce: ce %b want 1", cpu_ce); else n_pass++;
        n_chk++; if (state_out !== 2'b00) $display("FAIL bp_step_idle: state %b want 00", state_out); else n_pass++;
        n_chk++; if (pulses != 1) $display("FAIL bp_step_count: got %0d want 1", pulses); else n_pass++;
`else
        n_chk++; if (pulses != 1) $display("FAIL bp_ignored_ce: got %0d pulses want 1", pulses); else n_pass++;
        n_chk++; if (halted != 0) $display("FAIL bp_ignored_state: saw 11 on %0d clks want 0", halted); else n_pass++;
        n_chk++; if (state_out !== 2'b01) $display("FAIL bp_ignored_run: state %b want 01", state_out); else n_pass++;
`endif
        run_sw   = 1'b0;
        tick_in  = 1'b0;
        bp_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_chk++; if ({cpu_ce, state_out, cycle_cnt} !== {m_ce, m_mode, m_cnt})
            $display("FAIL bp_exit_model: ce/st/cnt %b/%b/%0d want %b/%b/%0d", cpu_ce, state_out, cycle_cnt, m_ce, m_mode, m_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int hp  = 8;
        int ph  = 0;
        int bad = 0;
        int ces = 0;
        bp_addr = 32'h0000_0008;
        for (int c = 0; c < 3000; c++) begin
            if (++ph >= hp) begin
                ph = 0;
                tick_in = ~tick_in;
                hp = int'($urandom_range(3, 15));
            end
            if ($urandom_range(0, 79) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 24) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 49) == 0) bp_valid = ~bp_valid;
            pc = 32'($urandom_range(0, 3) * 4);
            if (c == 1500) reset = 1'b0;
            if (c == 1503) reset = 1'b1;
            @(negedge clk);
            ces += int'(cpu_ce === 1'b1);
            n_chk++;
            if ({cpu_ce, state_out, cycle_cnt} !== {m_ce, m_mode, m_cnt}) begin
                if (bad < 10) $display("FAIL rand_model: clk %0d ce/st/cnt %b/%b/%0d want %b/%b/%0d", c, cpu_ce, state_out, cycle_cnt, m_ce, m_mode, m_cnt);
                bad++;
            end else n_pass++;
        end
        n_chk++; if (ces == 0) $display("FAIL rand_activity: got %0d ce pulses want >0", ces); else n_pass++;
        run_sw = 1'b0; step_btn = 1'b0; tick_in = 1'b0; bp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_step_debounce();
        test_run_drop();
        test_wrap();
        test_reset_mid_step();
        test_breakpoint();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
